regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
Shares the single register-file write port between the in-order pipeline Write-Back stage and an out-of-band long-latency unit (divider/multiplier) that returns results late. It keeps a 32-entry scoreboard of registers awaiting long results and stalls Decode on RAW/WAW hazards against them. It buffers long results in a small FIFO whenever the pipeline Write-Back stage owns the port. Its outputs drive the register file's we0/wr_addr0/wr_din0 in place of the raw Write-Back signals.

Parameters:
DEPTH, 4, long-result FIFO entries (power of two, >=2)
MAX_OUT, 4, max outstanding long ops in flight (scoreboard bits set)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
RS1D  in  5  Decode rs1 address
RS2D  in  5  Decode rs2 address
RdD  in  5  Decode rd address
RegWriteD  in  1  Decode instruction writes rd
LongD  in  1  Decode instruction is a long-latency op
RegWriteW  in  1  pipeline WB write enable
RdW  in  5  pipeline WB destination
ResultW  in  32  pipeline WB data
lu_valid  in  1  long unit result valid
lu_rd  in  5  long result destination
lu_data  in  32  long result data
lu_ready  out  1  scheduler accepts long result this cycle
stallD  out  1  hold Fetch/Decode, bubble into Execute
rf_we  out  1  register-file write enable
rf_waddr  out  5  register-file write address
rf_wdata  out  32  register-file write data
pending  out  32  scoreboard vector (debug/verification)

Behaviour:
- Reset (rst=0, async): scoreboard=0, FIFO empty (rd/wr ptr=0, count=0), outstanding=0. Outputs combinationally follow: pending=0, lu_ready=1, stallD=0, and rf_* follow WB inputs.
- Write-port priority each cycle: (1) pipeline WB if RegWriteW && RdW!=0; (2) else FIFO head if non-empty; (3) else direct bypass of lu_valid result. The rf_* outputs are combinational from this selection, giving zero added latency for WB. When no source is selected, rf_we=0 and rf_waddr/rf_wdata=0.
- Writes to x0 are never emitted. A long result with lu_rd=0 is accepted and discarded.
- lu_ready = FIFO not full. The handshake completes when lu_valid && lu_ready.
- A completed handshake that is not bypassed enters the FIFO. Bypass is allowed only when the FIFO is empty and WB is idle, so ordering is preserved.
- FIFO full: lu_ready=0 and the long unit must hold lu_rd/lu_data stable. Simultaneous pop and push at full is not accepted (lu_ready already 0).
- Scoreboard set: on issue = LongD && RegWriteD && RdD!=0 && !stallD. This sets pending[RdD] at the clock edge and increments outstanding.
- Scoreboard clear: when a long result (FIFO head or bypass) is written, clear pending[addr] and decrement outstanding. If issue and clear occur in the same cycle, outstanding is unchanged. An issue and a clear never target the same register, because WAW stall guarantees it.
- stallD = pending[RS1D] | pending[RS2D] | (RegWriteD && pending[RdD]) | (LongD && outstanding==MAX_OUT). Entries for x0 never count.
- Stall is evaluated against the registered scoreboard. A clear in cycle N releases the stall in cycle N+1 (conservative; no same-cycle bypass of the clear).
- A pipeline WB to a register with its pending bit set is a protocol error. It is flagged by an assertion only.
- Reset mid-operation drops all buffered and outstanding results. The long unit must be reset by the same rst.
- All counters use widths ceil(log2(DEPTH))+1 and ceil(log2(MAX_OUT))+1. Pointers wrap modulo DEPTH.

Decomposition:
- Package regfile_sched_pkg holds: the wb_src_e enum (SRC_NONE, SRC_WB, SRC_FIFO, SRC_BYPASS); the lu_entry_t struct {rd[4:0], data[31:0]}; and the DEPTH/MAX_OUT defaults.
- One sub-module, sched_fifo: a parameterised synchronous FIFO of lu_entry_t with full/empty/count outputs and async active-low reset. The scoreboard, counter, arbitration and stall logic stay in the top module.

Test Plan:
- Reset then idle, with RegWriteW=1, RdW=5, ResultW=0xA5 -> rf_we=1, rf_waddr=5, rf_wdata=0xA5 in the same cycle; pending=0; stallD=0.
- Issue long op with RdD=7; next cycle Decode RS1D=7 -> pending[7]=1, stallD=1 until the cycle after the lu result for rd 7 is written, then stallD=0.
- lu_valid with rd=3, data=0x1234 while WB writes rd 9 -> WB written first; rd 3 is written from the FIFO the following idle-WB cycle; pending[3] clears.
- Continuous WB writes, with 5 long results offered at DEPTH=4 -> lu_ready drops after 4 accepts; the 5th is held and accepted once WB idles; write order is FIFO order.
- Four outstanding long ops, then a fifth LongD -> stallD=1 until one result retires, then issue proceeds.
- Long result to rd 0 -> handshake completes, rf_we=0, no scoreboard change; async rst low mid-stream -> pending=0 and FIFO empty immediately.

Source files
------------

// File: rtl/regfile_wb_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sched_pkg
// Description : Shared types and defaults for the register-file write-back
//               scheduler: write-port source selector, long-result FIFO entry
//               and default sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_sched_pkg;

    // Which source owns the register-file write port this cycle
    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_WB     = 2'd1,
        SRC_FIFO   = 2'd2,
        SRC_BYPASS = 2'd3
    } wb_src_e;

    // One buffered long-latency result
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } lu_entry_t;

    localparam int DEPTH_DEFAULT   = 4;
    localparam int MAX_OUT_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_scheduler_if
// Description : Bundle of Decode, Write-Back, long-unit and register-file
//               write-port signals handled by the scheduler.
//   master : pipeline / long-unit side (drives Decode, WB and lu_* requests)
//   slave  : scheduler side (drives lu_ready, stallD, rf_*, pending)
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_scheduler_if;
    // Decode
    logic [4:0]  RS1D;
    logic [4:0]  RS2D;
    logic [4:0]  RdD;
    logic        RegWriteD;
    logic        LongD;
    // Pipeline Write-Back
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    // Long-latency unit result
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    // Scheduler outputs
    logic        stallD;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pending;

    modport master (
        output RS1D, RS2D, RdD, RegWriteD, LongD,
        output RegWriteW, RdW, ResultW,
        output lu_valid, lu_rd, lu_data,
        input  lu_ready, stallD, rf_we, rf_waddr, rf_wdata, pending
    );

    modport slave (
        input  RS1D, RS2D, RdD, RegWriteD, LongD,
        input  RegWriteW, RdW, ResultW,
        input  lu_valid, lu_rd, lu_data,
        output lu_ready, stallD, rf_we, rf_waddr, rf_wdata, pending
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_scheduler_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sched_fifo
// Description : Synchronous FIFO of long-latency results (lu_entry_t).
//   clk, rst        : clock, asynchronous active-low reset
//   push, push_data : write request / entry (ignored when full)
//   pop, pop_data   : read request (ignored when empty) / head entry
//   full, empty     : occupancy flags
//   count           : number of stored entries (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module sched_fifo
    import regfile_sched_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  lu_entry_t                  push_data,
    input  logic                       pop,
    output lu_entry_t                  pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    lu_entry_t         mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     cnt;
    logic              do_push;
    logic              do_pop;

    always_comb begin
        full     = (cnt == CW'(DEPTH));
        empty    = (cnt == '0);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        pop_data = mem[rd_ptr];
        count    = cnt;
    end

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_scheduler
// Description : Shares the register-file write port between the pipeline
//               Write-Back stage and a long-latency unit. Keeps a scoreboard
//               of registers awaiting long results, stalls Decode on RAW/WAW
//               hazards and buffers long results while WB owns the port.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : Decode / WB / long-unit inputs, rf_* write port, lu_ready,
//              stallD and the pending scoreboard vector
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler
    import regfile_sched_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEFAULT,
    parameter int MAX_OUT = MAX_OUT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_wb_scheduler_if.slave   bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUT) + 1;

    logic [31:0]    pending_q;
    logic [OW-1:0]  outstanding_q;

    lu_entry_t      fifo_head;
    lu_entry_t      fifo_in;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           fifo_push;
    logic           fifo_pop;

    wb_src_e        src;
    logic           wb_active;
    logic           lu_fire;
    logic           long_wr;
    logic [4:0]     long_rd;
    logic [31:0]    pend_eff;
    logic           stall;
    logic           issue;
    logic [31:0]    set_mask;
    logic [31:0]    clr_mask;

    sched_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        wb_active = bus.RegWriteW && (bus.RdW != 5'd0);
        lu_fire   = bus.lu_valid && !fifo_full;

        // Bypass only when nothing older is queued and WB is idle, which
        // keeps long results in arrival order. x0 results never select.
        if (wb_active) begin
            src = SRC_WB;
        end else if (!fifo_empty) begin
            src = SRC_FIFO;
        end else if (bus.lu_valid && (bus.lu_rd != 5'd0)) begin
            src = SRC_BYPASS;
        end else begin
            src = SRC_NONE;
        end

        fifo_in.rd   = bus.lu_rd;
        fifo_in.data = bus.lu_data;
        // x0 results are accepted but dropped instead of queued
        fifo_push    = lu_fire && (bus.lu_rd != 5'd0) && (src != SRC_BYPASS);
        fifo_pop     = (src == SRC_FIFO);

        long_wr = (src == SRC_FIFO) || (src == SRC_BYPASS);
        long_rd = (src == SRC_FIFO) ? fifo_head.rd : bus.lu_rd;

        bus.rf_we    = 1'b0;
        bus.rf_waddr = 5'd0;
        bus.rf_wdata = 32'd0;
        unique case (src)
            SRC_WB: begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = bus.RdW;
                bus.rf_wdata = bus.ResultW;
            end
            SRC_FIFO: begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = fifo_head.rd;
                bus.rf_wdata = fifo_head.data;
            end
            SRC_BYPASS: begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = bus.lu_rd;
                bus.rf_wdata = bus.lu_data;
            end
            default: begin
                bus.rf_we    = 1'b0;
            end
        endcase

        // Hazards are checked against the registered scoreboard only, so a
        // clear releases the stall one cycle later.
        pend_eff = {pending_q[31:1], 1'b0};
        stall    = pend_eff[bus.RS1D]
                 | pend_eff[bus.RS2D]
                 | (bus.RegWriteD && pend_eff[bus.RdD])
                 | (bus.LongD && (outstanding_q == OW'(MAX_OUT)));
        issue    = bus.LongD && bus.RegWriteD && (bus.RdD != 5'd0) && !stall;

        set_mask = issue   ? (32'd1 << bus.RdD) : 32'd0;
        clr_mask = long_wr ? (32'd1 << long_rd) : 32'd0;

        bus.lu_ready = !fifo_full;
        bus.stallD   = stall;
        bus.pending  = pending_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q     <= 32'd0;
            outstanding_q <= '0;
        end else begin
            pending_q <= (pending_q | set_mask) & ~clr_mask;
            case ({issue, long_wr})
                2'b10:   outstanding_q <= outstanding_q + OW'(1);
                2'b01:   outstanding_q <= outstanding_q - OW'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // Pipeline WB must never target a register still awaiting a long result.
    a_no_wb_to_pending: assert property (
        @(posedge clk) disable iff (!rst) !(wb_active && pending_q[bus.RdW])
    );

    a_fifo_bound: assert property (
        @(posedge clk) disable iff (!rst) fifo_count <= CW'(DEPTH)
    );
endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_scheduler
// Description : Self-checking bench for regfile_wb_scheduler. A queue-based
//               reference model predicts every output each cycle; directed
//               scenarios are followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_scheduler;
    import regfile_sched_pkg::*;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_scheduler_if bus ();

    regfile_wb_scheduler #(
        .DEPTH   (DEPTH),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model state
    bit          pend [32];
    int          outs;
    lu_entry_t   fq [$];
    logic [4:0]  lu_todo [$];
    bit          lu_acc;

    // Expected values for the current cycle
    logic        e_we, e_ready, e_stall, e_issue, e_long, e_pop, e_bypass;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata, e_pend;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        foreach (pend[i]) pend[i] = 1'b0;
        outs = 0;
        fq.delete();
        lu_todo.delete();
    endfunction

    function automatic void compute_exp();
        bit wb;
        wb       = bus.RegWriteW && (bus.RdW != 5'd0);
        e_ready  = (fq.size() < DEPTH);
        e_long   = 1'b0;
        e_pop    = 1'b0;
        e_bypass = 1'b0;
        e_we     = 1'b0;
        e_waddr  = 5'd0;
        e_wdata  = 32'd0;
        if (wb) begin
            e_we = 1'b1; e_waddr = bus.RdW; e_wdata = bus.ResultW;
        end else if (fq.size() > 0) begin
            e_we = 1'b1; e_waddr = fq[0].rd; e_wdata = fq[0].data;
            e_long = 1'b1; e_pop = 1'b1;
        end else if (bus.lu_valid && bus.lu_rd != 5'd0) begin
            e_we = 1'b1; e_waddr = bus.lu_rd; e_wdata = bus.lu_data;
            e_long = 1'b1; e_bypass = 1'b1;
        end
        e_stall = pend[bus.RS1D] || pend[bus.RS2D] ||
                  (bus.RegWriteD && pend[bus.RdD]) ||
                  (bus.LongD && outs == MAX_OUT);
        e_issue = bus.LongD && bus.RegWriteD && (bus.RdD != 5'd0) && !e_stall;
        for (int i = 0; i < 32; i++) e_pend[i] = pend[i];
    endfunction

    function automatic void model_update();
        lu_entry_t ent;
        if (e_pop) void'(fq.pop_front());
        if (e_long) begin
            pend[e_waddr] = 1'b0;
            outs--;
        end
        if (e_issue) begin
            pend[bus.RdD] = 1'b1;
            outs++;
            lu_todo.push_back(bus.RdD);
        end
        if (bus.lu_valid && e_ready) begin
            lu_acc = 1'b1;
            if (bus.lu_rd != 5'd0) begin
                if (!e_bypass) begin
                    ent.rd = bus.lu_rd; ent.data = bus.lu_data;
                    fq.push_back(ent);
                end
                for (int i = 0; i < lu_todo.size(); i++) begin
                    if (lu_todo[i] == bus.lu_rd) begin
                        lu_todo.delete(i);
                        break;
                    end
                end
            end
        end
    endfunction

    // Inputs are set at the falling edge before calling; checks land 1ns
    // later, the model advances at the rising edge, returns at next fall.
    task automatic cycle();
        #1;
        compute_exp();
        chk("rf_we",    {31'd0, bus.rf_we},    {31'd0, e_we});
        chk("rf_waddr", {27'd0, bus.rf_waddr}, {27'd0, e_waddr});
        chk("rf_wdata", bus.rf_wdata,          e_wdata);
        chk("lu_ready", {31'd0, bus.lu_ready}, {31'd0, e_ready});
        chk("stallD",   {31'd0, bus.stallD},   {31'd0, e_stall});
        chk("pending",  bus.pending,           e_pend);
        @(posedge clk);
        if (rst) model_update();
        else     model_reset();
        @(negedge clk);
    endtask

    task automatic set_idle();
        bus.RS1D = 5'd0; bus.RS2D = 5'd0; bus.RdD = 5'd0;
        bus.RegWriteD = 1'b0; bus.LongD = 1'b0;
        bus.RegWriteW = 1'b0; bus.RdW = 5'd0; bus.ResultW = 32'd0;
        bus.lu_valid = 1'b0; bus.lu_rd = 5'd0; bus.lu_data = 32'd0;
    endtask

    task automatic issue_long(input logic [4:0] rd);
        set_idle();
        bus.LongD = 1'b1; bus.RegWriteD = 1'b1; bus.RdD = rd;
        cycle();
    endtask

    task automatic lu_offer(input logic [4:0] rd, input logic [31:0] d);
        bus.lu_valid = 1'b1; bus.lu_rd = rd; bus.lu_data = d;
    endtask

    task automatic rand_drive();
        if (lu_acc) bus.lu_valid = 1'b0;
        lu_acc = 1'b0;
        if (!bus.lu_valid) begin
            if (lu_todo.size() > 0 && $urandom_range(0, 2) == 0)
                lu_offer(lu_todo[0], $urandom);
            else if ($urandom_range(0, 19) == 0)
                lu_offer(5'd0, $urandom);
        end
        bus.RS1D      = 5'($urandom_range(0, 7));
        bus.RS2D      = 5'($urandom_range(0, 7));
        bus.RdD       = 5'($urandom_range(0, 7));
        bus.LongD     = ($urandom_range(0, 2) == 0);
        bus.RegWriteD = ($urandom_range(0, 3) != 0);
        bus.RegWriteW = $urandom_range(0, 1);
        bus.RdW       = 5'($urandom_range(0, 7));
        if (pend[bus.RdW]) bus.RdW = 5'd0;
        bus.ResultW   = $urandom;
    endtask

    initial begin
        model_reset();
        lu_acc = 1'b0;
        set_idle();

        // Reset: WB passes straight through, scoreboard clear
        bus.RegWriteW = 1'b1; bus.RdW = 5'd5; bus.ResultW = 32'hA5;
        #1;
        chk("rst_rf_we",    {31'd0, bus.rf_we},    32'd1);
        chk("rst_rf_waddr", {27'd0, bus.rf_waddr}, 32'd5);
        chk("rst_rf_wdata", bus.rf_wdata,          32'hA5);
        chk("rst_pending",  bus.pending,           32'd0);
        chk("rst_stallD",   {31'd0, bus.stallD},   32'd0);
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();

        // RAW stall on a pending long result, released the cycle after write
        issue_long(5'd7);
        set_idle();
        bus.RS1D = 5'd7;
        #1 chk("raw_stall", {31'd0, bus.stallD}, 32'd1);
        chk("raw_pend7", bus.pending, 32'h80);
        cycle();
        cycle();
        lu_offer(5'd7, 32'h77);
        #1 chk("byp_waddr", {27'd0, bus.rf_waddr}, 32'd7);
        cycle();
        bus.lu_valid = 1'b0;
        #1 chk("raw_release", {31'd0, bus.stallD}, 32'd0);
        cycle();

        // Long result collides with WB: buffered, written next idle cycle
        issue_long(5'd3);
        set_idle();
        bus.RegWriteW = 1'b1; bus.RdW = 5'd9; bus.ResultW = 32'h999;
        lu_offer(5'd3, 32'h1234);
        #1 chk("wb_first", {27'd0, bus.rf_waddr}, 32'd9);
        cycle();
        set_idle();
        #1 chk("fifo_waddr", {27'd0, bus.rf_waddr}, 32'd3);
        chk("fifo_wdata", bus.rf_wdata, 32'h1234);
        cycle();
        #1 chk("pend3_clear", bus.pending, 32'd0);

        // FIFO fills under continuous WB; fifth result held until drain
        for (int i = 0; i < 4; i++) issue_long(5'(10 + i));
        set_idle();
        bus.RegWriteW = 1'b1; bus.RdW = 5'd20; bus.ResultW = 32'h2020;
        for (int i = 0; i < 4; i++) begin
            lu_offer(5'(10 + i), 32'h100 + i);
            cycle();
        end
        lu_offer(5'd0, 32'hDEAD);
        #1 chk("full_ready", {31'd0, bus.lu_ready}, 32'd0);
        cycle();
        bus.RegWriteW = 1'b0;
        #1 chk("drain0", {27'd0, bus.rf_waddr}, 32'd10);
        cycle();
        #1 chk("drain1", {27'd0, bus.rf_waddr}, 32'd11);
        chk("ready_back", {31'd0, bus.lu_ready}, 32'd1);
        cycle();
        bus.lu_valid = 1'b0;
        #1 chk("drain2", {27'd0, bus.rf_waddr}, 32'd12);
        cycle();
        #1 chk("drain3", {27'd0, bus.rf_waddr}, 32'd13);
        cycle();

        // Outstanding limit stalls a further long op
        for (int i = 0; i < 4; i++) issue_long(5'(14 + i));
        set_idle();
        bus.LongD = 1'b1; bus.RegWriteD = 1'b1; bus.RdD = 5'd18;
        #1 chk("max_out_stall", {31'd0, bus.stallD}, 32'd1);
        cycle();
        lu_offer(5'd14, 32'h14);
        cycle();
        bus.lu_valid = 1'b0;
        #1 chk("max_out_release", {31'd0, bus.stallD}, 32'd0);
        cycle();
        set_idle();
        for (int i = 0; i < 4; i++) begin
            lu_offer(5'(15 + i), 32'h15 + i);
            cycle();
        end

        // x0 result is consumed silently
        set_idle();
        lu_offer(5'd0, 32'hBEEF);
        #1 chk("x0_we", {31'd0, bus.rf_we}, 32'd0);
        chk("x0_ready", {31'd0, bus.lu_ready}, 32'd1);
        cycle();

        // Asynchronous reset with a result buffered
        issue_long(5'd21);
        set_idle();
        bus.RegWriteW = 1'b1; bus.RdW = 5'd22; bus.ResultW = 32'h22;
        lu_offer(5'd21, 32'h2121);
        cycle();
        bus.lu_valid = 1'b0;
        #2 rst = 1'b0;
        model_reset();
        #1 chk("arst_pending", bus.pending, 32'd0);
        chk("arst_ready", {31'd0, bus.lu_ready}, 32'd1);
        bus.RegWriteW = 1'b0;
        #1 chk("arst_fifo_empty", {31'd0, bus.rf_we}, 32'd0);
        @(negedge clk);
        set_idle();
        cycle();
        rst = 1'b1;
        cycle();

        // Randomized traffic against the model
        lu_acc = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            rand_drive();
            cycle();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
`default_nettype wire
